// File: rtl/user_popcount_seq.sv
// Sequencer that feeds a memory buffer into the set-bit-count accelerator over OBI and latches
// the 16-bit result; configured and started through an OBI subordinate register port.
module user_popcount_seq #(
  parameter logic [31:0] AccBaseAddr = 32'h2000_1000,
  parameter int unsigned LenWidth    = 16,
  parameter type obi_req_t = struct packed {
    logic req;
    struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
    } a;
  },
  parameter type obi_rsp_t = struct packed {
    logic gnt;
    logic rvalid;
    struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
    } r;
  }
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t sbr_obi_req_i,
  output obi_rsp_t sbr_obi_rsp_o,
  output obi_req_t mgr_obi_req_o,
  input  obi_rsp_t mgr_obi_rsp_i,
  output logic     busy_o,
  output logic     done_o
);

  typedef enum logic [2:0] {StIdle, StClr, StRd, StAcc, StRes} state_e;

  state_e              state_q, state_d;
  logic                wait_q, wait_d;  // 0: issuing request, 1: waiting for rvalid
  logic [31:0]         src_q, src_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [31:0]         ptr_q, ptr_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;
  logic [15:0]         result_q, result_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                sbr_rvalid_q, sbr_rvalid_d;
  logic [0:0]          sbr_rid_q, sbr_rid_d;
  logic [31:0]         sbr_rdata_q, sbr_rdata_d;
  logic                sbr_err_q, sbr_err_d;

  logic                busy;
  logic                start;

  assign busy   = (state_q != StIdle);
  assign busy_o = busy;
  assign done_o = done_q;

  // Register port: always granted, response one cycle later.
  always_comb begin
    start        = 1'b0;
    src_d        = src_q;
    len_d        = len_q;
    sbr_rvalid_d = sbr_obi_req_i.req;
    sbr_rid_d    = sbr_obi_req_i.a.aid;
    sbr_rdata_d  = '0;
    sbr_err_d    = 1'b0;
    if (sbr_obi_req_i.req) begin
      if (sbr_obi_req_i.a.we) begin
        case (sbr_obi_req_i.a.addr[3:2])
          2'd0: begin
            if (busy) sbr_err_d = 1'b1;
            else      src_d     = {sbr_obi_req_i.a.wdata[31:2], 2'b00};
          end
          2'd1: begin
            if (busy) sbr_err_d = 1'b1;
            else      len_d     = sbr_obi_req_i.a.wdata[LenWidth-1:0];
          end
          2'd2: begin
            if (busy) sbr_err_d = 1'b1;
            else      start     = sbr_obi_req_i.a.wdata[0];
          end
          default: sbr_err_d = 1'b1;
        endcase
      end else begin
        unique case (sbr_obi_req_i.a.addr[3:2])
          2'd0: sbr_rdata_d = src_q;
          2'd1: sbr_rdata_d = 32'(len_q);
          2'd2: sbr_rdata_d = '0;
          2'd3: sbr_rdata_d = {14'd0, err_q, busy, result_q};
        endcase
      end
    end
  end

  always_comb begin
    sbr_obi_rsp_o         = '0;
    sbr_obi_rsp_o.gnt     = sbr_obi_req_i.req;
    sbr_obi_rsp_o.rvalid  = sbr_rvalid_q;
    sbr_obi_rsp_o.r.rdata = sbr_rdata_q;
    sbr_obi_rsp_o.r.rid   = sbr_rid_q;
    sbr_obi_rsp_o.r.err   = sbr_err_q;
  end

  // Job FSM; the manager request fields depend only on state and held registers,
  // so they stay constant while a request waits for its grant.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;

    mgr_obi_req_o      = '0;
    mgr_obi_req_o.a.be = 4'hF;
    case (state_q)
      StClr: begin
        mgr_obi_req_o.a.addr = AccBaseAddr;
        mgr_obi_req_o.a.we   = 1'b1;
      end
      StRd: mgr_obi_req_o.a.addr = ptr_q;
      StAcc: begin
        mgr_obi_req_o.a.addr  = AccBaseAddr + 32'h4;
        mgr_obi_req_o.a.we    = 1'b1;
        mgr_obi_req_o.a.wdata = word_q;
      end
      StRes: mgr_obi_req_o.a.addr = AccBaseAddr + 32'h8;
      default: ;
    endcase
    mgr_obi_req_o.req = busy && !wait_q;

    if (!busy) begin
      if (start) begin
        err_d    = 1'b0;
        result_d = '0;
        ptr_d    = src_q;
        cnt_d    = len_q;
        wait_d   = 1'b0;
        state_d  = StClr;
      end
    end else if (!wait_q) begin
      if (mgr_obi_rsp_i.gnt) wait_d = 1'b1;
    end else if (mgr_obi_rsp_i.rvalid) begin
      wait_d = 1'b0;
      if (mgr_obi_rsp_i.r.err) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        case (state_q)
          StClr: state_d = (cnt_q != '0) ? StRd : StRes;
          StRd: begin
            word_d  = mgr_obi_rsp_i.r.rdata;
            state_d = StAcc;
          end
          StAcc: begin
            ptr_d   = ptr_q + 32'd4;
            cnt_d   = cnt_q - LenWidth'(1);
            state_d = (cnt_q != LenWidth'(1)) ? StRd : StRes;
          end
          StRes: begin
            result_d = mgr_obi_rsp_i.r.rdata[15:0];
            done_d   = 1'b1;
            state_d  = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wait_q       <= 1'b0;
      src_q        <= '0;
      len_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      sbr_rvalid_q <= 1'b0;
      sbr_rid_q    <= '0;
      sbr_rdata_q  <= '0;
      sbr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      src_q        <= src_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      result_q     <= result_d;
      err_q        <= err_d;
      done_q       <= done_d;
      sbr_rvalid_q <= sbr_rvalid_d;
      sbr_rid_q    <= sbr_rid_d;
      sbr_rdata_q  <= sbr_rdata_d;
      sbr_err_q    <= sbr_err_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sbr_obi_req_i.a.be, sbr_obi_req_i.a.addr, sbr_obi_req_i.a.wdata,
                         mgr_obi_rsp_i.r.rid};

endmodule

// File: tb/tb_user_popcount_seq.sv
// Directed bench for user_popcount_seq with a memory + popcount accelerator responder model.
module tb_user_popcount_seq;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } a_t;
  typedef struct packed {
    logic req;
    a_t   a;
  } req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } r_t;
  typedef struct packed {
    logic gnt;
    logic rvalid;
    r_t   r;
  } rsp_t;

  localparam logic [31:0] Acc = 32'h2000_1000;
  localparam logic [31:0] Mem = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  req_t sbr_req = '0;
  rsp_t sbr_rsp;
  req_t mgr_req;
  rsp_t mgr_rsp = '0;
  logic busy, done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic        stall_en = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          st = 0;
  int          rv_dly = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_rdata = '0;
  logic        pend_err = 1'b0;
  logic [15:0] acc = '0;
  int          txn_cnt = 0;
  int          done_cnt = 0;
  int          viol = 0;
  logic        snap_v = 1'b0;
  req_t        snap = '0;

  user_popcount_seq #(
    .AccBaseAddr(Acc),
    .LenWidth   (16),
    .obi_req_t  (req_t),
    .obi_rsp_t  (rsp_t)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sbr_obi_req_i(sbr_req),
    .sbr_obi_rsp_o(sbr_rsp),
    .mgr_obi_req_o(mgr_req),
    .mgr_obi_rsp_i(mgr_rsp),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Memory / accelerator responder, one transaction outstanding, optional random stalls.
  always @(negedge clk) begin
    mgr_rsp <= '0;
    snap_v  <= 1'b0;
    if (snap_v && mgr_req.req && (mgr_req.a != snap.a)) viol <= viol + 1;
    if (pend) begin
      if (rv_dly == 0) begin
        mgr_rsp.rvalid  <= 1'b1;
        mgr_rsp.r.rdata <= pend_rdata;
        mgr_rsp.r.err   <= pend_err;
        pend            <= 1'b0;
      end else begin
        rv_dly <= rv_dly - 1;
      end
    end else if (mgr_req.req) begin
      if (st == 0) begin
        mgr_rsp.gnt <= 1'b1;
        txn_cnt     <= txn_cnt + 1;
        pend        <= 1'b1;
        rv_dly      <= stall_en ? int'($urandom_range(0, 5)) : 0;
        st          <= stall_en ? int'($urandom_range(0, 5)) : 0;
        if (mgr_req.a.we) begin
          if (mgr_req.a.addr == Acc) acc <= '0;
          else if (mgr_req.a.addr == Acc + 32'h4)
            acc <= acc + 16'($countones(mgr_req.a.wdata));
          pend_rdata <= '0;
          pend_err   <= 1'b0;
        end else begin
          pend_rdata <= (mgr_req.a.addr == Acc + 32'h8) ? {16'h0, acc} : mem[mgr_req.a.addr[7:2]];
          pend_err   <= err_en && (mgr_req.a.addr == err_addr);
        end
      end else begin
        st     <= st - 1;
        snap   <= mgr_req;
        snap_v <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic sbr(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    sbr_req.req     = 1'b1;
    sbr_req.a.we    = we;
    sbr_req.a.addr  = addr;
    sbr_req.a.wdata = wdata;
    sbr_req.a.be    = 4'hF;
    sbr_req.a.aid   = 1'b0;
    @(negedge clk);
    sbr_req = '0;
    rdata   = sbr_rsp.r.rdata;
    err     = sbr_rsp.r.err;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          txn0, done0, n;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hAAAA_AAAA;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mgr_req", {31'd0, mgr_req.req}, 32'd0);
    chk("rst_sbr_rvalid", {31'd0, sbr_rsp.rvalid}, 32'd0);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("rst_status", rd, 32'h0);
    sbr(1'b0, 32'h4, '0, rd, er);
    chk("rst_len", rd, 32'h0);

    // Handshake: gnt same cycle, rvalid one cycle later with rid echo
    @(negedge clk);
    sbr_req.req    = 1'b1;
    sbr_req.a.addr = 32'h8;
    sbr_req.a.aid  = 1'b1;
    #1 chk("hs_gnt", {31'd0, sbr_rsp.gnt}, 32'd1);
    chk("hs_rvalid_early", {31'd0, sbr_rsp.rvalid}, 32'd0);
    @(negedge clk);
    sbr_req = '0;
    chk("hs_rvalid", {31'd0, sbr_rsp.rvalid}, 32'd1);
    chk("hs_rid", {31'd0, sbr_rsp.r.rid}, 32'd1);
    chk("ctrl_read", sbr_rsp.r.rdata, 32'd0);
    chk("ctrl_read_err", {31'd0, sbr_rsp.r.err}, 32'd0);
    @(negedge clk);
    chk("hs_rvalid_once", {31'd0, sbr_rsp.rvalid}, 32'd0);

    // 1: three-word job
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0001; mem[2] = 32'h0;
    sbr(1'b1, 32'h0, Mem | 32'h3, rd, er);
    sbr(1'b0, 32'h0, '0, rd, er);
    chk("src_align", rd, Mem);
    sbr(1'b1, 32'h4, 32'd3, rd, er);
    txn0 = txn_cnt; done0 = done_cnt;
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1_done");
    chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t1_done_pulses", done_cnt - done0, 32'd1);
    chk("t1_txns", txn_cnt - txn0, 32'd8);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t1_status", rd, 32'd33);

    // 2: LEN=0
    sbr(1'b1, 32'h4, 32'd0, rd, er);
    txn0 = txn_cnt;
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    wait_done("t2_done");
    @(negedge clk);
    chk("t2_txns", txn_cnt - txn0, 32'd2);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t2_status", rd, 32'h0);

    // 3: sixteen words with random stalls
    for (int i = 0; i < 16; i++) mem[i] = 32'hAAAA_AAAA;
    stall_en = 1'b1;
    sbr(1'b1, 32'h4, 32'd16, rd, er);
    txn0 = txn_cnt; n = viol;
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    wait_done("t3_done");
    @(negedge clk);
    stall_en = 1'b0;
    @(negedge clk);
    chk("t3_txns", txn_cnt - txn0, 32'd34);
    chk("t3_stable", viol - n, 32'd0);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t3_status", rd, 32'd256);

    // 4: error response on word 2 of 4
    err_en = 1'b1; err_addr = Mem + 32'h4;
    sbr(1'b1, 32'h4, 32'd4, rd, er);
    txn0 = txn_cnt; done0 = done_cnt;
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    wait_done("t4_done");
    @(negedge clk);
    chk("t4_busy_after", {31'd0, busy}, 32'd0);
    chk("t4_txns", txn_cnt - txn0, 32'd4);
    chk("t4_done_pulses", done_cnt - done0, 32'd1);
    err_en = 1'b0;
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t4_status", rd, 32'h0002_0000);

    // 5: writes while busy
    sbr(1'b1, 32'h4, 32'd8, rd, er);
    done0 = done_cnt;
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    sbr(1'b1, 32'h0, 32'h2222_2220, rd, er);
    chk("t5_src_err", {31'd0, er}, 32'd1);
    sbr(1'b1, 32'h4, 32'd5, rd, er);
    chk("t5_len_err", {31'd0, er}, 32'd1);
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    chk("t5_ctrl_err", {31'd0, er}, 32'd1);
    sbr(1'b1, 32'hC, 32'd0, rd, er);
    chk("t5_status_wr_err", {31'd0, er}, 32'd1);
    chk("t5_err_rdata", rd, 32'd0);
    sbr(1'b0, 32'h0, '0, rd, er);
    chk("t5_src_kept", rd, Mem);
    sbr(1'b0, 32'h4, '0, rd, er);
    chk("t5_len_kept", rd, 32'd8);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t5_status_busy", rd, 32'h0001_0000);
    wait_done("t5_done");
    @(negedge clk);
    chk("t5_done_pulses", done_cnt - done0, 32'd1);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t5_status", rd, 32'd128);
    sbr(1'b1, 32'hC, 32'd0, rd, er);
    chk("t5_idle_status_wr_err", {31'd0, er}, 32'd1);

    // 6: reset during ACC
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    n = 0;
    while (!(mgr_req.req && mgr_req.a.we && mgr_req.a.addr == Acc + 32'h4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_acc", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_mgr_req", {31'd0, mgr_req.req}, 32'd0);
    sbr(1'b0, 32'h0, '0, rd, er);
    chk("t6_src", rd, 32'h0);
    sbr(1'b0, 32'h4, '0, rd, er);
    chk("t6_len", rd, 32'h0);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t6_status", rd, 32'h0);
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0001; mem[2] = 32'h0;
    sbr(1'b1, 32'h0, Mem, rd, er);
    sbr(1'b1, 32'h4, 32'd3, rd, er);
    txn0 = txn_cnt; done0 = done_cnt;
    sbr(1'b1, 32'h8, 32'd1, rd, er);
    wait_done("t6_rerun_done");
    @(negedge clk);
    chk("t6_rerun_txns", txn_cnt - txn0, 32'd8);
    chk("t6_rerun_pulses", done_cnt - done0, 32'd1);
    sbr(1'b0, 32'hC, '0, rd, er);
    chk("t6_rerun_status", rd, 32'd33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
